// File: rtl/i2c_master_burst_read_if.sv
// ---------------------------------------------------------------------------
// i2c_master_burst_read_if
// Bundles the request/response handshake and the I2C pad signals of the
// burst-read I2C master.
//   start     request pulse from the sequencer (accepted only when !busy)
//   dev_addr  7-bit slave address        reg_addr  start register address
//   len       bytes to read minus one
//   busy      transfer in progress       done      end-of-transfer strobe
//   rd_data   received byte              rd_valid  per-byte strobe
//   ack_err   slave NACK flag, valid with done
//   scl       push-pull SCL              sda_oe    1 = pull SDA low
//   sda       SDA pad value
// Modport master is the I2C master block itself; modport slave is the
// sequencer/pad side that drives requests and the SDA pad value.
// ---------------------------------------------------------------------------
interface i2c_master_burst_read_if #(
  parameter int unsigned LEN_W = 4
);
  logic             start;
  logic [6:0]       dev_addr;
  logic [7:0]       reg_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic             ack_err;
  logic             scl;
  logic             sda_oe;
  logic             sda;

  modport master (
    input  start, dev_addr, reg_addr, len, sda,
    output busy, rd_data, rd_valid, done, ack_err, scl, sda_oe
  );

  modport slave (
    output start, dev_addr, reg_addr, len, sda,
    input  busy, rd_data, rd_valid, done, ack_err, scl, sda_oe
  );
endinterface

// File: rtl/i2c_master_burst_read.sv
// ---------------------------------------------------------------------------
// i2c_master_burst_read
// I2C master performing random-address burst reads:
//   START, dev+W, reg, repeated START, dev+R, N data bytes (ACK all but the
//   last, NACK the last), STOP.  A slave NACK on any address/register byte
//   aborts to STOP and reports ack_err together with done.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset; releases the bus immediately
//   bus    i2c_master_burst_read_if.master (request, response and pads)
// Parameters
//   CLK_DIV  clk cycles per SCL period (multiple of 4, >= 8)
//   LEN_W    width of bus.len; burst length = len + 1
// Timing: one SCL period per bit.  SCL is high for the first half of the
// period; HM (quarter point) is the sample/START/STOP point, LM (three
// quarter point) is the only place SDA changes for data.  Each state owns
// the bus from one LM to the next, so the SDA value for a state's bit is
// set on entry at the LM before it.
// ---------------------------------------------------------------------------
module i2c_master_burst_read #(
  parameter int unsigned CLK_DIV = 500,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  i2c_master_burst_read_if.master        bus
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_HM   = CNT_W'(CLK_DIV / 4);
  localparam logic [CNT_W-1:0] CNT_LM   = CNT_W'((3 * CLK_DIV) / 4);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_TX,
    S_SACK,
    S_RSTART,
    S_RX,
    S_MACK,
    S_STOP,
    S_DONE
  } state_t;

  // Which byte of the header is being sent; selects the step after SACK.
  typedef enum logic [1:0] {
    PH_DEVW,
    PH_REG,
    PH_DEVR
  } phase_t;

  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hm;
  logic             lm;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] left;      // data bytes remaining after the current one
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic [2:0]       bit_cnt;
  logic             nack;

  always_comb begin
    cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    hm      = (cnt == CNT_HM);
    lm      = (cnt == CNT_LM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      phase        <= PH_DEVW;
      cnt          <= '0;
      dev_q        <= '0;
      reg_q        <= '0;
      left         <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bit_cnt      <= '0;
      nack         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;
      bus.ack_err  <= 1'b0;
      bus.scl      <= 1'b1;
      bus.sda_oe   <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;

      // SCL is registered from the next counter value so it always equals
      // (cnt < CLK_DIV/2) while a transfer is running.
      if (state != S_IDLE && state != S_DONE) begin
        cnt     <= cnt_nxt;
        bus.scl <= (cnt_nxt < CNT_HALF);
      end

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_START;
            dev_q       <= bus.dev_addr;
            reg_q       <= bus.reg_addr;
            left        <= bus.len;
            nack        <= 1'b0;
            bus.ack_err <= 1'b0;
            bus.busy    <= 1'b1;
            cnt         <= '0;
            bus.scl     <= 1'b1;
            bus.sda_oe  <= 1'b0;
          end
        end

        S_START: begin
          if (hm) begin
            bus.sda_oe <= 1'b1;
          end else if (lm) begin
            state      <= S_TX;
            phase      <= PH_DEVW;
            tx_sh      <= {dev_q, 1'b0};
            bit_cnt    <= 3'd7;
            bus.sda_oe <= ~dev_q[6];
          end
        end

        S_TX: begin
          if (lm) begin
            if (bit_cnt == 3'd0) begin
              state      <= S_SACK;
              bus.sda_oe <= 1'b0;
            end else begin
              bus.sda_oe <= ~tx_sh[6];
              tx_sh      <= {tx_sh[6:0], 1'b0};
              bit_cnt    <= bit_cnt - 3'd1;
            end
          end
        end

        S_SACK: begin
          if (hm) begin
            if (bus.sda) nack <= 1'b1;
          end else if (lm) begin
            if (nack) begin
              state      <= S_STOP;
              bus.sda_oe <= 1'b1;
            end else begin
              unique case (phase)
                PH_DEVW: begin
                  state      <= S_TX;
                  phase      <= PH_REG;
                  tx_sh      <= reg_q;
                  bit_cnt    <= 3'd7;
                  bus.sda_oe <= ~reg_q[7];
                end
                PH_REG: begin
                  // Release SDA while SCL is low so it is high when SCL rises.
                  state      <= S_RSTART;
                  bus.sda_oe <= 1'b0;
                end
                default: begin
                  state      <= S_RX;
                  bit_cnt    <= 3'd7;
                  bus.sda_oe <= 1'b0;
                end
              endcase
            end
          end
        end

        S_RSTART: begin
          if (hm) begin
            bus.sda_oe <= 1'b1;
          end else if (lm) begin
            state      <= S_TX;
            phase      <= PH_DEVR;
            tx_sh      <= {dev_q, 1'b1};
            bit_cnt    <= 3'd7;
            bus.sda_oe <= ~dev_q[6];
          end
        end

        S_RX: begin
          if (hm) begin
            rx_sh <= {rx_sh[6:0], bus.sda};
            if (bit_cnt == 3'd0) begin
              bus.rd_data  <= {rx_sh[6:0], bus.sda};
              bus.rd_valid <= 1'b1;
            end
          end else if (lm) begin
            if (bit_cnt == 3'd0) begin
              state      <= S_MACK;
              bus.sda_oe <= (left != '0);
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
        end

        S_MACK: begin
          if (lm) begin
            if (left != '0) begin
              state      <= S_RX;
              left       <= left - LEN_W'(1);
              bit_cnt    <= 3'd7;
              bus.sda_oe <= 1'b0;
            end else begin
              state      <= S_STOP;
              bus.sda_oe <= 1'b1;
            end
          end
        end

        S_STOP: begin
          // Leave right at HM so SCL is never pulled low after STOP.
          if (hm) begin
            state       <= S_DONE;
            bus.sda_oe  <= 1'b0;
            bus.done    <= 1'b1;
            bus.ack_err <= nack;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          cnt      <= '0;
          bus.scl  <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
